timer_regif: RTL
================

# timer_regif

Register-interface and update controller for the timer core. It owns every configuration register the timer consumes and decodes a simple single-cycle word bus from the host. Period, divisor and match values are double-buffered through shadow registers and committed atomically on a safe update event, so the running counter never sees a torn configuration. Status and interrupt flags are collected into a sticky, write-1-to-clear pending register that drives one interrupt line.

## Interface
- COUNTER_SIZE, 32, counter/match/limit width (1..32)
- PRESCALER_BIT, 32, divisor width (1..32)

- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-low reset
- wr_i  in  1  write strobe, one cycle per access
- rd_i  in  1  read strobe, one cycle per access
- addr_i  in  4  word address
- wdata_i  in  32  write data
- rdata_o  out  32  read data, valid while ready_o=1
- ready_o  out  1  read-data-valid pulse
- ctrl_reg_o, ctrl_intr_o, ctrl_pwm_o  out  8 each  control registers to the timer core
- divisor_sync_o, divisor_async_o  out  PRESCALER_BIT  active divisors
- cnt_init_start_o, cnt_min_o, cnt_max_o  out  COUNTER_SIZE  active counter limits
- match0_o, match1_o  out  COUNTER_SIZE  active compare values
- status_i  in  8  timer status; bit0 = overflow
- intr_flag_i  in  8  timer interrupt flags; bits[2:0] = OVF, M0, M1
- cnt_sync_i, cnt_async_i  in  COUNTER_SIZE  live counter values
- irq_o  out  1  OR of the enabled pending bits

## Operation
- Address map:
  - 0 CTRL_REG, 1 CTRL_INTR, 2 CTRL_PWM: direct registers, take effect on the write edge.
  - Shadowed registers: 3 DIV_SYNC, 4 DIV_ASYNC, 5 INIT_START, 6 MIN, 7 MAX, 8 MATCH0, 9 MATCH1.
  - 10 STATUS: read-only.
  - 11 IRQ_PEND: bits[2:0], write-1-to-clear.
  - 12 CNT_SYNC, 13 CNT_ASYNC: read-only.
  - 14 CMD: bit0 FORCE_UPDATE, write-only, self-clearing, reads 0.
  - 15 PENDING: read-only; bits[6:0] map to shadows 3..9.
- Writes to read-only addresses are ignored.
- Writes use the low bits of wdata_i. Reads zero-extend to 32 bits.
- Shadow write: loads the shadow register and sets the matching PENDING bit.
- Update FSM states: IDLE, ARMED, COMMIT.
  - IDLE -> COMMIT when PENDING≠0 and (ctrl_reg_o[0]=0 or FORCE_UPDATE).
  - IDLE -> ARMED when PENDING≠0 and ctrl_reg_o[0]=1.
  - ARMED -> COMMIT on ovf_rise, FORCE_UPDATE, or ctrl_reg_o[0] falling to 0.
  - COMMIT: copies every pending shadow to its active register, clears the PENDING bits that were committed, then -> IDLE.
- ovf_rise = status_i[0] & ~ovf_q, where ovf_q is status_i[0] registered.
- Interrupt pending bits: IRQ_PEND[i] sets on the rising edge of intr_flag_i[i].
- irq_o = |(IRQ_PEND & ctrl_intr_o[2:0]).
- Simultaneous events:
  - Shadow write in the COMMIT cycle: the active register takes the old shadow value; the new value stays pending (set wins over clear).
  - IRQ set and W1C in the same cycle: set wins.
  - wr_i and rd_i in the same cycle are both performed; the read returns the pre-write value.
- Reset mid-operation: all state returns to reset values immediately and any pending update is discarded.

## Timing
- Reset values:
  - cnt_max_o and its shadow: all ones.
  - All other active and shadow registers: 0.
  - PENDING, IRQ_PEND, irq_o, rdata_o, ready_o, ovf_q: 0.
  - FSM: IDLE.
- Read latency: rd_i sampled at edge N -> rdata_o/ready_o valid for exactly one cycle after edge N.
- Direct-register write: output changes after the write edge.
- Shadow write with timer stopped, at edge N:
  - PENDING set after N;
  - COMMIT after N+1;
  - active output updated after N+2.
- Running timer: ovf_rise high in the cycle ending at edge M -> COMMIT after M; active outputs update after M+1.
- irq_o: asserts one cycle after the edge that registers the flag rise; deasserts one cycle after the W1C write.

## Structure
- Package timer_pkg holds:
  - address localparams;
  - the update-FSM state enum;
  - CTRL_REG, CTRL_INTR and STATUS bit indices, shared with the timer core.
- One sub-module: timer_edge_det, a registered rising-edge detector, instantiated for the overflow bit and for the three interrupt flags.

## Test plan
- Reset: check every output value.
- Then write MAX=0x100 with CTRL_REG=0 -> cnt_max_o=0x100 two cycles after the write edge; PENDING reads 0.
- CTRL_REG=0x01, write MATCH0=0x40 -> match0_o unchanged and PENDING=0x20.
  - Pulse status_i[0] -> match0_o=0x40 two edges after the rising edge; PENDING=0.
- Running timer, write DIV_SYNC=5, then CMD=1 -> divisor_sync_o=5 without any overflow.
- CTRL_INTR=0x01, pulse intr_flag_i[0] -> irq_o=1 and IRQ_PEND=1.
  - Write 1 to IRQ_PEND in the same cycle as a new rise -> IRQ_PEND stays 1.
  - Write 1 to IRQ_PEND with no new rise -> irq_o=0.
- Shadow write to MIN in the COMMIT cycle -> cnt_min_o takes the old value; PENDING[3]=1 remains.
  - Assert rst_i=0 while in ARMED -> FSM IDLE, PENDING=0, outputs at reset values.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the timer register interface and timer core:
// register map, update-controller states and control/status bit positions.
package timer_pkg;

    localparam logic [3:0] ADDR_CTRL_REG   = 4'd0;
    localparam logic [3:0] ADDR_CTRL_INTR  = 4'd1;
    localparam logic [3:0] ADDR_CTRL_PWM   = 4'd2;
    localparam logic [3:0] ADDR_DIV_SYNC   = 4'd3;
    localparam logic [3:0] ADDR_DIV_ASYNC  = 4'd4;
    localparam logic [3:0] ADDR_INIT_START = 4'd5;
    localparam logic [3:0] ADDR_MIN        = 4'd6;
    localparam logic [3:0] ADDR_MAX        = 4'd7;
    localparam logic [3:0] ADDR_MATCH0     = 4'd8;
    localparam logic [3:0] ADDR_MATCH1     = 4'd9;
    localparam logic [3:0] ADDR_STATUS     = 4'd10;
    localparam logic [3:0] ADDR_IRQ_PEND   = 4'd11;
    localparam logic [3:0] ADDR_CNT_SYNC   = 4'd12;
    localparam logic [3:0] ADDR_CNT_ASYNC  = 4'd13;
    localparam logic [3:0] ADDR_CMD        = 4'd14;
    localparam logic [3:0] ADDR_PENDING    = 4'd15;

    localparam int unsigned NUM_SHADOW = 7;
    localparam int unsigned NUM_IRQ    = 3;

    localparam int unsigned CTRL_REG_EN   = 0;
    localparam int unsigned CTRL_INTR_OVF = 0;
    localparam int unsigned CTRL_INTR_M0  = 1;
    localparam int unsigned CTRL_INTR_M1  = 2;
    localparam int unsigned STATUS_OVF    = 0;

    typedef enum logic [1:0] {
        UPD_IDLE,
        UPD_ARMED,
        UPD_COMMIT
    } upd_state_t;

endpackage

// File: rtl/timer_edge_det.sv
// Registered rising-edge detector; rise_o is high while the input is 1
// and its registered copy is still 0.
module timer_edge_det #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] level_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] level_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) level_q <= '0;
        else        level_q <= level_i;
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/timer_regif.sv
// Host register interface for the timer: direct control registers, shadowed
// configuration committed atomically by the update FSM, and W1C interrupts.
module timer_regif
    import timer_pkg::*;
#(
    parameter int unsigned COUNTER_SIZE  = 32,
    parameter int unsigned PRESCALER_BIT = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic                     rd_i,
    input  logic [3:0]               addr_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic                     ready_o,
    output logic [7:0]               ctrl_reg_o,
    output logic [7:0]               ctrl_intr_o,
    output logic [7:0]               ctrl_pwm_o,
    output logic [PRESCALER_BIT-1:0] divisor_sync_o,
    output logic [PRESCALER_BIT-1:0] divisor_async_o,
    output logic [COUNTER_SIZE-1:0]  cnt_init_start_o,
    output logic [COUNTER_SIZE-1:0]  cnt_min_o,
    output logic [COUNTER_SIZE-1:0]  cnt_max_o,
    output logic [COUNTER_SIZE-1:0]  match0_o,
    output logic [COUNTER_SIZE-1:0]  match1_o,
    input  logic [7:0]               status_i,
    input  logic [7:0]               intr_flag_i,
    input  logic [COUNTER_SIZE-1:0]  cnt_sync_i,
    input  logic [COUNTER_SIZE-1:0]  cnt_async_i,
    output logic                     irq_o
);

    upd_state_t state_q, state_d;

    logic [PRESCALER_BIT-1:0] div_sync_sh, div_async_sh;
    logic [COUNTER_SIZE-1:0]  init_start_sh, min_sh, max_sh, match0_sh, match1_sh;
    logic [NUM_SHADOW-1:0]    pending_q, shadow_set, commit_mask;
    logic [NUM_IRQ-1:0]       irq_pend_q, irq_rise, irq_w1c;
    logic                     ovf_rise, force_update, commit;
    logic [31:0]              rdata_d;
    logic                     unused_flags;

    assign unused_flags = ^intr_flag_i[7:NUM_IRQ];

    timer_edge_det #(.WIDTH(1)) u_ovf_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .level_i (status_i[STATUS_OVF]),
        .rise_o  (ovf_rise)
    );

    timer_edge_det #(.WIDTH(NUM_IRQ)) u_irq_edge (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .level_i (intr_flag_i[NUM_IRQ-1:0]),
        .rise_o  (irq_rise)
    );

    always_comb begin
        shadow_set = '0;
        if (wr_i) begin
            case (addr_i)
                ADDR_DIV_SYNC:   shadow_set = 7'b0000001;
                ADDR_DIV_ASYNC:  shadow_set = 7'b0000010;
                ADDR_INIT_START: shadow_set = 7'b0000100;
                ADDR_MIN:        shadow_set = 7'b0001000;
                ADDR_MAX:        shadow_set = 7'b0010000;
                ADDR_MATCH0:     shadow_set = 7'b0100000;
                ADDR_MATCH1:     shadow_set = 7'b1000000;
                default:         shadow_set = '0;
            endcase
        end
    end

    assign force_update = wr_i && (addr_i == ADDR_CMD) && wdata_i[0];
    assign irq_w1c      = (wr_i && (addr_i == ADDR_IRQ_PEND)) ? wdata_i[NUM_IRQ-1:0] : '0;
    assign commit       = (state_q == UPD_COMMIT);
    assign commit_mask  = commit ? pending_q : '0;
    assign irq_o        = |(irq_pend_q & ctrl_intr_o[NUM_IRQ-1:0]);

    always_comb begin
        state_d = state_q;
        case (state_q)
            UPD_IDLE: begin
                if (pending_q != '0) begin
                    if (!ctrl_reg_o[CTRL_REG_EN] || force_update) state_d = UPD_COMMIT;
                    else                                           state_d = UPD_ARMED;
                end
            end
            UPD_ARMED: begin
                if (ovf_rise || force_update || !ctrl_reg_o[CTRL_REG_EN]) state_d = UPD_COMMIT;
            end
            UPD_COMMIT: state_d = UPD_IDLE;
            default:    state_d = UPD_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = '0;
        case (addr_i)
            ADDR_CTRL_REG:   rdata_d = 32'(ctrl_reg_o);
            ADDR_CTRL_INTR:  rdata_d = 32'(ctrl_intr_o);
            ADDR_CTRL_PWM:   rdata_d = 32'(ctrl_pwm_o);
            ADDR_DIV_SYNC:   rdata_d = 32'(div_sync_sh);
            ADDR_DIV_ASYNC:  rdata_d = 32'(div_async_sh);
            ADDR_INIT_START: rdata_d = 32'(init_start_sh);
            ADDR_MIN:        rdata_d = 32'(min_sh);
            ADDR_MAX:        rdata_d = 32'(max_sh);
            ADDR_MATCH0:     rdata_d = 32'(match0_sh);
            ADDR_MATCH1:     rdata_d = 32'(match1_sh);
            ADDR_STATUS:     rdata_d = 32'(status_i);
            ADDR_IRQ_PEND:   rdata_d = 32'(irq_pend_q);
            ADDR_CNT_SYNC:   rdata_d = 32'(cnt_sync_i);
            ADDR_CNT_ASYNC:  rdata_d = 32'(cnt_async_i);
            ADDR_PENDING:    rdata_d = 32'(pending_q);
            default:         rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= UPD_IDLE;
            pending_q  <= '0;
            irq_pend_q <= '0;
            rdata_o    <= '0;
            ready_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            // A shadow written during COMMIT re-arms its bit after the clear.
            pending_q  <= (pending_q & ~commit_mask) | shadow_set;
            irq_pend_q <= (irq_pend_q & ~irq_w1c) | irq_rise;
            rdata_o    <= rd_i ? rdata_d : '0;
            ready_o    <= rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl_reg_o    <= '0;
            ctrl_intr_o   <= '0;
            ctrl_pwm_o    <= '0;
            div_sync_sh   <= '0;
            div_async_sh  <= '0;
            init_start_sh <= '0;
            min_sh        <= '0;
            max_sh        <= '1;
            match0_sh     <= '0;
            match1_sh     <= '0;
        end else if (wr_i) begin
            case (addr_i)
                ADDR_CTRL_REG:   ctrl_reg_o    <= wdata_i[7:0];
                ADDR_CTRL_INTR:  ctrl_intr_o   <= wdata_i[7:0];
                ADDR_CTRL_PWM:   ctrl_pwm_o    <= wdata_i[7:0];
                ADDR_DIV_SYNC:   div_sync_sh   <= wdata_i[PRESCALER_BIT-1:0];
                ADDR_DIV_ASYNC:  div_async_sh  <= wdata_i[PRESCALER_BIT-1:0];
                ADDR_INIT_START: init_start_sh <= wdata_i[COUNTER_SIZE-1:0];
                ADDR_MIN:        min_sh        <= wdata_i[COUNTER_SIZE-1:0];
                ADDR_MAX:        max_sh        <= wdata_i[COUNTER_SIZE-1:0];
                ADDR_MATCH0:     match0_sh     <= wdata_i[COUNTER_SIZE-1:0];
                ADDR_MATCH1:     match1_sh     <= wdata_i[COUNTER_SIZE-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            divisor_sync_o   <= '0;
            divisor_async_o  <= '0;
            cnt_init_start_o <= '0;
            cnt_min_o        <= '0;
            cnt_max_o        <= '1;
            match0_o         <= '0;
            match1_o         <= '0;
        end else if (commit) begin
            if (pending_q[0]) divisor_sync_o   <= div_sync_sh;
            if (pending_q[1]) divisor_async_o  <= div_async_sh;
            if (pending_q[2]) cnt_init_start_o <= init_start_sh;
            if (pending_q[3]) cnt_min_o        <= min_sh;
            if (pending_q[4]) cnt_max_o        <= max_sh;
            if (pending_q[5]) match0_o         <= match0_sh;
            if (pending_q[6]) match1_o         <= match1_sh;
        end
    end

endmodule
